// File: rtl/morse_symbol_capture.sv
// Morse key capture: debounces the key, times presses/gaps in clk_div ticks,
// packs dot/dash symbols per letter and emits each letter as a 1-cycle pulse.
// Ports: CLK, RST_N (async low), clk_div (tick source), key_in (raw key)
//        -> sym_bits/sym_len (last letter), letter_valid, letter_err,
//           key_active (debounced key), busy (FSM not idle).
module morse_symbol_capture #(
  parameter int DOT_MAX_TICKS    = 3,
  parameter int LETTER_GAP_TICKS = 6,
  parameter int MAX_SYMBOLS      = 5,
  parameter int DEBOUNCE_CYCLES  = 4,
  parameter int CNT_W            = 8,
  localparam int LEN_W = $clog2(MAX_SYMBOLS + 1)
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   clk_div,
  input  logic                   key_in,
  output logic [MAX_SYMBOLS-1:0] sym_bits,
  output logic [LEN_W-1:0]       sym_len,
  output logic                   letter_valid,
  output logic                   letter_err,
  output logic                   key_active,
  output logic                   busy
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [CNT_W-1:0] DOT_MAX =
    CNT_W'(DOT_MAX_TICKS);
  localparam logic [CNT_W-1:0] GAP_LAST =
    CNT_W'(LETTER_GAP_TICKS - 1);
  localparam logic [DB_W-1:0] DB_LAST =
    DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LEN_W-1:0] SYM_MAX =
    LEN_W'(MAX_SYMBOLS);

  typedef enum logic [1:0] {
    IDLE,
    PRESS,
    GAP,
    EMIT
  } state_t;

  state_t state;

  logic clk_div_q;
  logic tick;

  logic key_s1;
  logic key_s2;
  logic key_db;
  logic [DB_W-1:0] db_cnt;

  logic [CNT_W-1:0] press_cnt;
  logic [CNT_W-1:0] gap_cnt;
  logic [MAX_SYMBOLS-1:0] sym_buf;
  logic [LEN_W-1:0] sym_cnt;
  logic ovf;
  logic dash;

  // Reset to 1 so a high clk_div at reset release is not seen as an edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      clk_div_q <= 1'b1;
    end else begin
      clk_div_q <= clk_div;
    end
  end

  assign tick = clk_div & ~clk_div_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      key_s1 <= 1'b0;
      key_s2 <= 1'b0;
      key_db <= 1'b0;
      db_cnt <= '0;
    end else begin
      key_s1 <= key_in;
      key_s2 <= key_s1;
      if (key_s2 == key_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        key_db <= key_s2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign key_active = key_db;
  assign busy       = (state != IDLE);
  assign dash       = (press_cnt > DOT_MAX);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= IDLE;
      press_cnt    <= '0;
      gap_cnt      <= '0;
      sym_buf      <= '0;
      sym_cnt      <= '0;
      ovf          <= 1'b0;
      sym_bits     <= '0;
      sym_len      <= '0;
      letter_valid <= 1'b0;
      letter_err   <= 1'b0;
    end else begin
      letter_valid <= 1'b0;
      letter_err   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (key_db) begin
            state     <= PRESS;
            press_cnt <= '0;
          end
        end
        PRESS: begin
          if (!key_db) begin
            if (sym_cnt < SYM_MAX) begin
              for (int i = 0; i < MAX_SYMBOLS; i++) begin
                if (LEN_W'(i) == sym_cnt) begin
                  sym_buf[i] <= dash;
                end
              end
              sym_cnt <= sym_cnt + 1'b1;
            end else begin
              ovf <= 1'b1;
            end
            state   <= GAP;
            gap_cnt <= '0;
          end else if (tick && press_cnt != '1) begin
            press_cnt <= press_cnt + 1'b1;
          end
        end
        GAP: begin
          // A new press beats a gap-completing tick.
          if (key_db) begin
            state     <= PRESS;
            press_cnt <= '0;
          end else if (tick) begin
            if (gap_cnt == GAP_LAST) begin
              state <= EMIT;
            end
            if (gap_cnt != '1) begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
        end
        EMIT: begin
          if (ovf) begin
            letter_err <= 1'b1;
          end else begin
            letter_valid <= 1'b1;
            sym_bits     <= sym_buf;
            sym_len      <= sym_cnt;
          end
          sym_buf <= '0;
          sym_cnt <= '0;
          ovf     <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_morse_symbol_capture.sv
// Bench for morse_symbol_capture: letters, dot/dash boundary, overflow,
// reset, debounce, gap race and counter saturation; scoreboard-checked.
module tb_morse_symbol_capture;

  logic       CLK     = 1'b0;
  logic       RST_N   = 1'b0;
  logic       clk_div = 1'b0;
  logic       key_in  = 1'b0;
  logic [4:0] sym_bits;
  logic [2:0] sym_len;
  logic       letter_valid;
  logic       letter_err;
  logic       key_active;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int div_ph = 0;
  int cyc = 0;
  int pulses = 0;
  int last_pulse_cyc = -1;
  logic prev_pulse = 1'b0;

  typedef struct packed {
    logic       err;
    logic [4:0] bits;
    logic [2:0] len;
  } exp_t;

  exp_t sb[$];

  morse_symbol_capture dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .clk_div(clk_div),
    .key_in(key_in),
    .sym_bits(sym_bits),
    .sym_len(sym_len),
    .letter_valid(letter_valid),
    .letter_err(letter_err),
    .key_active(key_active),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // clk_div: period 50 CLK, rises when div_ph wraps to 0.
  always @(negedge CLK) begin
    div_ph = (div_ph + 1) % 50;
    clk_div = (div_ph < 25);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1);
  end

  task automatic monitor();
    exp_t e;
    exp_t got;
    logic pulse;
    forever begin
      @(negedge CLK);
      pulse = letter_valid | letter_err;
      if (RST_N) begin
        if (letter_valid && letter_err) begin
          checks++;
          errors++;
          $display("FAIL both_pulses: valid=%b err=%b, required never both",
                   letter_valid, letter_err);
        end
        if (pulse && prev_pulse) begin
          checks++;
          errors++;
          $display("FAIL pulse_width: pulse high 2 cycles, required 1");
        end
        if (pulse) begin
          pulses++;
          last_pulse_cyc = cyc;
          checks++;
          got = {letter_err, sym_bits, sym_len};
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_letter: err=%b bits=%b len=%0d, required none",
                     letter_err, sym_bits, sym_len);
          end else begin
            e = sb.pop_front();
            if (got !== e) begin
              errors++;
              $display("FAIL letter: err=%b bits=%b len=%0d, required err=%b bits=%b len=%0d",
                       got.err, got.bits, got.len, e.err, e.bits, e.len);
            end
          end
        end
      end
      prev_pulse = pulse;
    end
  endtask

  task automatic wait_ph(input int p);
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      #1;
      n++;
    end while (div_ph != p && n < 200);
    if (div_ph != p) begin
      checks++;
      errors++;
      $display("FAIL wait_phase: phase=%0d, required %0d", div_ph, p);
    end
  endtask

  task automatic push(input logic err, input logic [4:0] bits,
                      input logic [2:0] len);
    exp_t e;
    e.err  = err;
    e.bits = bits;
    e.len  = len;
    sb.push_back(e);
  endtask

  task automatic press(input int n);
    wait_ph(12);
    key_in = 1'b1;
    repeat (n) wait_ph(0);
    wait_ph(12);
    key_in = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) wait_ph(0);
  endtask

  task automatic end_letter(input string name);
    repeat (8) wait_ph(0);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d letters pending, required 0",
               name, sb.size());
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    key_in = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    checks++;
    if ({sym_bits, sym_len, letter_valid, letter_err, key_active, busy} !== 11'd0) begin
      errors++;
      $display("FAIL reset_state: bits=%b len=%0d v=%b e=%b ka=%b busy=%b, required all 0",
               sym_bits, sym_len, letter_valid, letter_err, key_active, busy);
    end
    RST_N = 1'b1;
  endtask

  task automatic test_letter_a();
    int exp_cyc;
    push(1'b0, 5'b00010, 3'd2);
    press(2);
    gap(2);
    press(5);
    repeat (6) wait_ph(0);
    exp_cyc = cyc + 2;
    repeat (2) wait_ph(0);
    checks++;
    if (last_pulse_cyc !== exp_cyc) begin
      errors++;
      $display("FAIL a_latency: pulse cycle=%0d, required %0d",
               last_pulse_cyc, exp_cyc);
    end
    end_letter("a");
  endtask

  task automatic test_dot_dash_boundary();
    push(1'b0, 5'b00000, 3'd1);
    press(3);
    end_letter("e");
    push(1'b0, 5'b00001, 3'd1);
    press(4);
    end_letter("t");
  endtask

  task automatic test_overflow();
    push(1'b1, 5'b00001, 3'd1);
    repeat (6) begin
      press(1);
      gap(1);
    end
    end_letter("overflow");
  endtask

  task automatic test_reset_mid();
    int p0;
    press(1);
    gap(1);
    press(1);
    gap(1);
    wait_ph(12);
    key_in = 1'b1;
    repeat (2) wait_ph(0);
    RST_N = 1'b0;
    #1;
    checks++;
    if ({sym_bits, sym_len, letter_valid, letter_err, key_active, busy} !== 11'd0) begin
      errors++;
      $display("FAIL reset_mid: bits=%b len=%0d v=%b e=%b ka=%b busy=%b, required all 0",
               sym_bits, sym_len, letter_valid, letter_err, key_active, busy);
    end
    key_in = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    RST_N = 1'b1;
    p0 = pulses;
    gap(10);
    checks++;
    if (pulses != p0) begin
      errors++;
      $display("FAIL reset_discard: %0d pulses after reset, required 0",
               pulses - p0);
    end
  endtask

  task automatic test_debounce();
    int seen_active;
    int seen_busy;
    int n;
    seen_active = 0;
    seen_busy = 0;
    wait_ph(20);
    for (int g = 0; g < 4; g++) begin
      key_in = 1'b1;
      for (int c = 0; c < 12; c++) begin
        @(negedge CLK);
        #1;
        if (c == 2) key_in = 1'b0;
        seen_active += int'(key_active);
        seen_busy += int'(busy);
      end
    end
    checks++;
    if (seen_active != 0) begin
      errors++;
      $display("FAIL glitch_key_active: high %0d cycles, required 0",
               seen_active);
    end
    checks++;
    if (seen_busy != 0) begin
      errors++;
      $display("FAIL glitch_busy: high %0d cycles, required 0", seen_busy);
    end
    push(1'b0, 5'b00000, 3'd1);
    wait_ph(20);
    key_in = 1'b1;
    n = 0;
    do begin
      @(negedge CLK);
      #1;
      n++;
    end while (!key_active && n < 20);
    checks++;
    if (n != 6) begin
      errors++;
      $display("FAIL debounce_latency: %0d cycles, required 6", n);
    end
    repeat (2) wait_ph(0);
    wait_ph(12);
    key_in = 1'b0;
    end_letter("debounce");
  endtask

  task automatic test_gap_boundary();
    push(1'b0, 5'b00010, 3'd2);
    press(1);
    gap(5);
    wait_ph(44);
    key_in = 1'b1;
    repeat (6) wait_ph(0);
    wait_ph(12);
    key_in = 1'b0;
    end_letter("gap_race");
  endtask

  task automatic test_saturation();
    push(1'b0, 5'b00001, 3'd1);
    press(300);
    end_letter("sat300");
    push(1'b0, 5'b00001, 3'd1);
    press(257);
    end_letter("sat257");
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_letter_a();
    test_dot_dash_boundary();
    test_overflow();
    test_reset_mid();
    test_debounce();
    test_gap_boundary();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/morse_symbol_capture.md
Name: morse_symbol_capture

Overview:
Downstream consumer of the 25-count clock divider's clk_div output in the Morse decoder. It debounces the Morse key and times each press and gap in divider ticks. Each press is classified as dot or dash, and the symbols are packed into a per-letter code word. When the inter-letter gap elapses, it emits the code word and its length as a one-cycle-valid letter to the downstream character lookup stage.

Parameters:
DOT_MAX_TICKS, 3, press lasting <= this many ticks is a dot; longer is a dash
LETTER_GAP_TICKS, 6, released ticks that close the current letter
MAX_SYMBOLS, 5, maximum symbols per letter
DEBOUNCE_CYCLES, 4, consecutive stable CLK cycles needed to accept a key level change
CNT_W, 8, width of the press and gap tick counters (saturating)

Ports:
CLK  input  1  system clock; single clock domain
RST_N  input  1  asynchronous active-low reset
clk_div  input  1  divider output, generated from CLK; its rising edge is one timing tick
key_in  input  1  raw Morse key, active-high, asynchronous, bouncy
sym_bits  output  MAX_SYMBOLS  code word of the last emitted letter; bit i = symbol i (bit 0 = first symbol), 1 = dash, 0 = dot; unused bits 0
sym_len  output  clog2(MAX_SYMBOLS+1)  symbol count of the last emitted letter
letter_valid  output  1  one-cycle pulse: sym_bits/sym_len just updated
letter_err  output  1  one-cycle pulse: letter exceeded MAX_SYMBOLS and was discarded
key_active  output  1  debounced key level (LED drive)
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async assert, sync release): all outputs 0; state IDLE; all counters, symbol buffer and overflow flag cleared. Reset mid-letter discards the partial letter with no pulse.
- Tick generation: clk_div is registered once. tick = clk_div & ~clk_div_q, which is a one-CLK pulse per rising edge. No tick is generated on the first cycle after reset.
- Key path: 2-flop synchroniser, then debounce. key_db changes only after the synced value has differed from key_db for DEBOUNCE_CYCLES consecutive CLK cycles; any agreeing cycle restarts the count. key_active = key_db. The FSM sees only key_db edges.
- State IDLE: key_db rises -> PRESS, press_cnt = 0.
- State PRESS: press_cnt increments on each tick and saturates at 2^CNT_W-1, with no wrap.
  - On key_db fall: symbol = (press_cnt > DOT_MAX_TICKS).
  - If count < MAX_SYMBOLS: store the symbol at bit [count], then count++. Otherwise set the overflow flag.
  - Then -> GAP, gap_cnt = 0.
- State GAP: gap_cnt increments on each tick, saturating.
  - key_db rise -> PRESS, press_cnt = 0 (same letter continues).
  - Otherwise, a tick making gap_cnt reach LETTER_GAP_TICKS -> EMIT.
  - A key rise in the same cycle as the completing tick wins: the letter continues.
- State EMIT (exactly one cycle), then -> IDLE, clearing the buffer, count and overflow:
  - Overflow set: letter_err = 1 next cycle; sym_bits and sym_len hold their previous values.
  - Overflow clear: sym_bits <= buffer, sym_len <= count, letter_valid = 1 next cycle.
- Latency: tick at cycle T completes the gap -> EMIT at T+1 -> letter_valid/letter_err high at T+2 only.
- sym_bits and sym_len are registered and stable between emissions.
- letter_valid and letter_err are never high together.
- A press of 0 ticks (release before any tick) is a dot.

Test Plan:
- Reset: assert RST_N low mid-PRESS with 2 symbols buffered -> all outputs 0 immediately. After release and 10 idle ticks, no letter_valid or letter_err occurs.
- Letter "A": clk_div period 50 CLK; press 2 ticks, gap 2 ticks, press 5 ticks, release 6 ticks -> letter_valid exactly 1 cycle, sym_bits=00010, sym_len=2, letter_valid asserted 2 cycles after the 6th gap tick.
- Dot/dash boundary: press exactly 3 ticks -> sym_bits=00000, sym_len=1 ("E"). Press 4 ticks -> sym_bits=00001, sym_len=1 ("T").
- Overflow: 6 dots separated by 1-tick gaps, after a prior "T" -> letter_err 1 cycle, letter_valid stays 0, sym_bits=00001 and sym_len=1 held.
- Bounce and debounce: 3-cycle key_in glitches -> key_active stays 0, busy stays 0. A clean press -> key_active rises 2+4 CLK cycles after key_in.
- Gap and saturation boundaries:
  - Key press debounced in the same cycle as the 6th gap tick -> no emission; the next symbol joins the same letter.
  - Hold the key for 300 ticks -> press_cnt stops at 255, the symbol is a dash, no wrap to a dot.
